mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 28, block address width; DATA_W, default 128, block data width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all state on rising edge
- proc_reset  in  1  synchronous, active-high reset
- i_read  in  1  I-cache block read request
- i_write  in  1  I-cache block write request
- i_addr  in  ADDR_W  I-cache block address
- i_wdata  in  DATA_W  I-cache write data
- i_rdata  out  DATA_W  read data to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same directions and widths as i_*, for the D-cache
- mem_read  out  1  memory read request, level
- mem_write  out  1  memory write request, level
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
REQ-003 Clock and reset SHALL be: one clock (clk); reset proc_reset synchronous and active-high.

Function
REQ-004 The block SHALL share one memory port between two cache ports, serving one transaction at a time.
REQ-005 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-006 IDLE: when either port requests (read or write high), the block SHALL grant one port, latch its address, op and wdata, and enter BUSY next cycle.
REQ-007 Simultaneous requests SHALL use round-robin: the grant goes to the port not granted last; the priority pointer updates on every grant.
REQ-008 A port asserting read and write together SHALL be treated as a write.
REQ-009 BUSY: mem_read/mem_write SHALL be registered, driven from the latched op, and held with constant mem_addr/mem_wdata until mem_ready.
REQ-010 In BUSY with mem_ready=1: mem_read/mem_write SHALL drop at the next edge; a read SHALL capture mem_rdata into the shared rdata register; the FSM SHALL enter RESP.
REQ-011 RESP: the granted port's ready SHALL be high for exactly one cycle; the other port's ready SHALL stay 0; the next state SHALL be IDLE.
REQ-012 Latency: request sampled in IDLE at edge t -> mem request high from t+1; mem_ready at edge m -> ready pulse at m+1 -> IDLE at m+2, when new requests are sampled.
REQ-013 i_rdata and d_rdata SHALL both drive the shared rdata register. Writes SHALL leave it unchanged, and it SHALL hold its value until the next read completes.
REQ-014 mem_ready SHALL be ignored outside BUSY.
REQ-015 Upstream requests that change while not granted SHALL not affect the transaction in flight.
REQ-016 No queuing beyond one in-flight transaction; a losing requester SHALL wait in IDLE arbitration.

Reset
REQ-017 On proc_reset high at an edge: state=IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, i_ready=0, d_ready=0, priority pointer = I-port first.
REQ-018 Reset mid-transaction SHALL abandon it with no ready pulse; a mem_ready arriving afterwards SHALL be ignored.

Structure
REQ-019 A shared package SHALL hold: ADDR_W/DATA_W defaults, FSM state encoding, and the port-select encoding (PORT_I=0, PORT_D=1).
REQ-020 The round-robin selection SHALL be a sub-module mem_arb_rr, with inputs req[1:0] and last_grant and output grant; it is combinational.
REQ-021 The top SHALL contain the FSM, latch registers and rdata register.

Verification
REQ-022 I read alone: i_read=1, i_addr=0x0000010; memory returns 0x...DEAD after 3 cycles -> mem_read high 3 cycles with mem_addr=0x0000010; i_ready pulses once; i_rdata=0x...DEAD; d_ready stays 0.
REQ-023 Simultaneous requests after reset: i_read and d_write (d_addr=0x0000020, d_wdata=0x1111...) both high -> I granted first; then D gets mem_write with the latched addr/data; d_ready pulses; rdata unchanged by the write.
REQ-024 Fairness: both ports request continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-025 Spurious mem_ready in IDLE -> no state change; no ready pulse; rdata unchanged.
REQ-026 Reset in BUSY, then mem_ready 1 cycle later -> mem_read=0 after the reset edge; no i_ready/d_ready; state IDLE; the next I request is served normally.
REQ-027 d_read and d_write both high -> memory sees mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// FSM state encoding and port-select encoding.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin select: on a tie the port not granted last wins.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = PORT_I;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-memory port between the I-cache and D-cache ports,
// one transaction in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            r_state;
  logic              r_port;
  logic              r_last_grant;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_i_ready;
  logic              r_d_ready;

  logic [1:0]        w_req;
  logic              w_grant;

  assign w_req = {d_read | d_write, i_read | i_write};

  mem_arb_rr u_rr (
    .req        (w_req),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Memory request registers double as the latched op/address/data.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state      <= ST_IDLE;
      r_port       <= PORT_I;
      r_last_grant <= PORT_D;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          if (|w_req) begin
            r_port       <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= ST_BUSY;
            if (w_grant == PORT_D) begin
              r_mem_write <= d_write;
              r_mem_read  <= ~d_write;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_write <= i_write;
              r_mem_read  <= ~i_write;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= i_wdata;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) begin
              r_rdata <= mem_rdata;
            end
            r_i_ready <= (r_port == PORT_I);
            r_d_ready <= (r_port == PORT_D);
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_rdata;
  assign d_rdata   = r_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;

endmodule
